// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control for the 5-stage MIPS core: load-use stalls, branch/jump
// flushes and multi-cycle mult/div sequencing with a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6,
    parameter int STAT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_jump,
    input  logic              id_md_start,
    input  logic              id_md_use,
    input  logic [4:0]        ex_rd,
    input  logic              ex_memread,
    input  logic              ex_branch_taken,
    output logic              insert_nop,
    output logic              PCdst,
    output logic              pc_en,
    output logic              id_ex_bubble,
    output logic              md_busy,
    output logic              md_done,
    output logic [STAT_W-1:0] stall_cycles
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] MD_RELOAD = CNT_W'(MD_LATENCY - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   md_cnt_q, md_cnt_d;
    logic               md_done_q, md_done_d;
    logic [STAT_W-1:0]  stall_q, stall_d;

    logic lu_haz;
    logic md_haz;
    logic redirect;
    logic md_issue;
    logic md_zero;

    // Same-cycle hazard terms
    always_comb begin
        md_zero  = (md_cnt_q == {CNT_W{1'b0}});
        lu_haz   = ex_memread && (ex_rd != 5'd0) &&
                   ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
        md_haz   = (state_q == MD_WAIT) && id_md_use && !md_zero;
        redirect = ex_branch_taken || id_jump;
        md_issue = id_md_start && !ex_branch_taken && !lu_haz;
    end

    // Prioritised pipeline control outputs; reset forces the pipeline to free-run
    always_comb begin
        insert_nop   = 1'b0;
        PCdst        = 1'b0;
        id_ex_bubble = 1'b0;
        pc_en        = 1'b1;
        if (reset) begin
            insert_nop = 1'b0;
        end else if (redirect) begin
            // A taken branch also kills the wrong-path instruction already in ID
            PCdst        = 1'b1;
            id_ex_bubble = ex_branch_taken;
        end else if (lu_haz || md_haz) begin
            insert_nop   = 1'b1;
            pc_en        = 1'b0;
            id_ex_bubble = 1'b1;
        end else begin
            insert_nop = 1'b0;
        end
    end

    // Mult/div sequencer; a committed operation keeps counting through flushes
    always_comb begin
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        md_done_d = 1'b0;
        case (state_q)
            RUN: begin
                if (md_issue) begin
                    state_d  = MD_WAIT;
                    md_cnt_d = MD_RELOAD;
                end else begin
                    state_d = RUN;
                end
            end
            MD_WAIT: begin
                if (md_zero) begin
                    md_done_d = 1'b1;
                    if (md_issue) begin
                        md_cnt_d = MD_RELOAD;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    md_cnt_d = md_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d  = RUN;
                md_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Saturating count of stalled cycles
    always_comb begin
        if (insert_nop && !(&stall_q)) begin
            stall_d = stall_q + STAT_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            md_cnt_q  <= {CNT_W{1'b0}};
            md_done_q <= 1'b0;
            stall_q   <= {STAT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            md_cnt_q  <= md_cnt_d;
            md_done_q <= md_done_d;
            stall_q   <= stall_d;
        end
    end

    assign md_busy      = (state_q == MD_WAIT);
    assign md_done      = md_done_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MD_LATENCY=4 and STAT_W=4.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rs, id_uses_rt, id_jump, id_md_start, id_md_use;
    logic       ex_memread, ex_branch_taken;
    logic       insert_nop, PCdst, pc_en, id_ex_bubble, md_busy, md_done;
    logic [3:0] stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(6), .STAT_W(4)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .id_md_start(id_md_start), .id_md_use(id_md_use),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
        .insert_nop(insert_nop), .PCdst(PCdst), .pc_en(pc_en), .id_ex_bubble(id_ex_bubble),
        .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0;
        id_md_start = 1'b0; id_md_use = 1'b0;
        ex_memread = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        ex_memread = 1'b1; ex_rd = r; id_rs = r; id_uses_rs = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        set_lu(5'd8);
        ex_branch_taken = 1'b1;
        #2;
        check_eq("rst_pcdst", PCdst, 0);
        check_eq("rst_nop", insert_nop, 0);
        check_eq("rst_bubble", id_ex_bubble, 0);
        check_eq("rst_pc_en", pc_en, 1);
        check_eq("rst_busy", md_busy, 0);
        check_eq("rst_done", md_done, 0);
        check_eq("rst_stall", stall_cycles, 0);
        idle();
        tick(); tick();
        reset = 1'b0;

        // Load-use on rs
        set_lu(5'd8);
        #1;
        check_eq("lu_nop", insert_nop, 1);
        check_eq("lu_pc_en", pc_en, 0);
        check_eq("lu_bubble", id_ex_bubble, 1);
        check_eq("lu_pcdst", PCdst, 0);
        tick();
        idle();
        #1;
        check_eq("lu_released", insert_nop, 0);
        check_eq("lu_stall1", stall_cycles, 1);
        // Load to r0 never stalls
        set_lu(5'd0);
        #1;
        check_eq("lu_r0_nop", insert_nop, 0);
        tick();
        check_eq("lu_r0_stall", stall_cycles, 1);
        // Load-use on rt, then same match with rt unused
        idle();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
        #1;
        check_eq("lu_rt_nop", insert_nop, 1);
        tick();
        check_eq("lu_rt_stall", stall_cycles, 2);
        id_uses_rt = 1'b0;
        #1;
        check_eq("lu_rt_unused", insert_nop, 0);

        // Branch beats load-use
        idle();
        set_lu(5'd8);
        ex_branch_taken = 1'b1;
        #1;
        check_eq("br_pcdst", PCdst, 1);
        check_eq("br_nop", insert_nop, 0);
        check_eq("br_bubble", id_ex_bubble, 1);
        check_eq("br_pc_en", pc_en, 1);
        tick();
        check_eq("br_stall", stall_cycles, 2);
        // Jump beats load-use, no bubble
        ex_branch_taken = 1'b0; id_jump = 1'b1;
        #1;
        check_eq("j_pcdst", PCdst, 1);
        check_eq("j_bubble", id_ex_bubble, 0);
        check_eq("j_nop", insert_nop, 0);
        check_eq("j_pc_en", pc_en, 1);
        tick();
        check_eq("j_stall", stall_cycles, 2);

        // Mult followed by mflo
        idle();
        pulse_reset();
        check_eq("mul_stall0", stall_cycles, 0);
        id_md_start = 1'b1;
        #1;
        check_eq("mul_busy0", md_busy, 0);
        tick();
        id_md_start = 1'b0; id_md_use = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            #1;
            check_eq($sformatf("mul_nop_c%0d", i), insert_nop, 1);
            check_eq($sformatf("mul_busy_c%0d", i), md_busy, 1);
            check_eq($sformatf("mul_done_c%0d", i), md_done, 0);
            tick();
        end
        #1;
        check_eq("mul_zero_nop", insert_nop, 0);
        check_eq("mul_zero_busy", md_busy, 1);
        tick();
        id_md_use = 1'b0;
        #1;
        check_eq("mul_end_busy", md_busy, 0);
        check_eq("mul_end_done", md_done, 1);
        check_eq("mul_stall3", stall_cycles, 3);
        tick();
        check_eq("mul_done_clr", md_done, 0);

        // Back-to-back div, with a flush in the second wait
        idle();
        pulse_reset();
        id_md_start = 1'b1;
        tick();
        id_md_use = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            if (c == 5) begin id_md_start = 1'b0; id_md_use = 1'b0; end
            ex_branch_taken = (c == 6);
            #1;
            check_eq($sformatf("b2b_busy_c%0d", c), md_busy, (c <= 8) ? 1 : 0);
            check_eq($sformatf("b2b_done_c%0d", c), md_done, (c == 5 || c == 9) ? 1 : 0);
            if (c <= 4) check_eq($sformatf("b2b_nop_c%0d", c), insert_nop, (c <= 3) ? 1 : 0);
            if (c == 6) check_eq("b2b_flush", PCdst, 1);
            tick();
        end
        check_eq("b2b_stall", stall_cycles, 3);

        // Issue suppressed by a taken branch or a load-use hazard
        idle();
        id_md_start = 1'b1; ex_branch_taken = 1'b1;
        tick();
        check_eq("md_br_ignored", md_busy, 0);
        ex_branch_taken = 1'b0;
        set_lu(5'd9);
        tick();
        check_eq("md_lu_ignored", md_busy, 0);

        // Async reset in the middle of a wait
        idle();
        pulse_reset();
        id_md_start = 1'b1;
        tick();
        id_md_start = 1'b0; id_md_use = 1'b1;
        tick();
        check_eq("ar_busy_pre", md_busy, 1);
        check_eq("ar_stall_pre", stall_cycles, 1);
        reset = 1'b1;
        #1;
        check_eq("ar_busy", md_busy, 0);
        check_eq("ar_stall", stall_cycles, 0);
        check_eq("ar_nop", insert_nop, 0);
        check_eq("ar_pc_en", pc_en, 1);
        reset = 1'b0;
        idle();
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("ar_no_done_%0d", i), md_done, 0);
            check_eq($sformatf("ar_no_busy_%0d", i), md_busy, 0);
        end

        // Saturation of the 4-bit stall counter
        idle();
        pulse_reset();
        set_lu(5'd3);
        for (int i = 1; i <= 20; i++) begin
            tick();
            check_eq($sformatf("sat_%0d", i), stall_cycles, (i < 15) ? i : 15);
        end
        check_eq("sat_nop", insert_nop, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage MIPS core.
- Drives the IF/ID register's stall (insert_nop) and flush (PCdst) inputs, the PC write enable, and the ID/EX bubble.
- Detects load-use hazards and taken-branch/jump redirects.
- Sequences the multi-cycle multiply/divide unit: holds dependent instructions in ID until the result is ready, and keeps a stall-cycle statistics counter.

Parameters:
- MD_LATENCY, 32, cycles from mult/div issue until HI/LO are valid (legal range 2..63).
- CNT_W, 6, width of the mult/div down-counter.
- STAT_W, 16, width of the saturating stall statistics counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_jump  in  1  ID instruction is j/jal/jr (redirect decided in ID)
- id_md_start  in  1  ID instruction is mult/multu/div/divu
- id_md_use  in  1  ID instruction is mfhi/mflo/mthi/mtlo or another mult/div
- ex_rd  in  5  destination register of the instruction in EX
- ex_memread  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch resolved taken in EX
- insert_nop  out  1  hold IF/ID (to IF_ID.insert_nop)
- PCdst  out  1  zero IF/ID on the next edge (to IF_ID.PCdst)
- pc_en  out  1  PC register write enable
- id_ex_bubble  out  1  load a NOP into ID/EX on the next edge
- md_busy  out  1  mult/div in progress
- md_done  out  1  one-cycle pulse when HI/LO become valid
- stall_cycles  out  STAT_W  cycles with insert_nop=1, saturating

Behaviour:
- Reset (async): state=RUN, md_cnt=0, stall_cycles=0, md_done=0.
- While reset is high, all combinational outputs are forced: insert_nop=0, PCdst=0, id_ex_bubble=0, pc_en=1.
- Hazard terms, all combinational, same-cycle:
  - lu_haz = ex_memread & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd))
  - md_haz = (state==MD_WAIT) & id_md_use & !(md_cnt==0)
  - redirect = ex_branch_taken | id_jump
- Output priority (highest first): reset > ex_branch_taken > id_jump > lu_haz > md_haz.
  - ex_branch_taken: PCdst=1, id_ex_bubble=1, insert_nop=0, pc_en=1 (the wrong-path ID instruction is discarded, so no stall).
  - id_jump (no branch): PCdst=1, id_ex_bubble=0, insert_nop=0, pc_en=1.
  - lu_haz or md_haz: insert_nop=1, pc_en=0, id_ex_bubble=1, PCdst=0.
  - Otherwise: insert_nop=0, PCdst=0, id_ex_bubble=0, pc_en=1.
- FSM, two states:
  - RUN: id_md_start & !ex_branch_taken & !lu_haz -> MD_WAIT, md_cnt<=MD_LATENCY-1.
  - MD_WAIT: md_cnt decrements each cycle. At md_cnt==0, md_done=1 (registered pulse, visible the cycle after the zero cycle) and:
    - if id_md_start & !ex_branch_taken & !lu_haz -> stay in MD_WAIT, reload MD_LATENCY-1 (back-to-back issue);
    - else -> RUN.
  - md_busy = (state==MD_WAIT).
- md_haz is released in the md_cnt==0 cycle, so a stalled mfhi/mflo advances on that edge. Total stall for an mflo immediately after a mult = MD_LATENCY-1 cycles.
- ex_branch_taken during MD_WAIT: flush as above; the counter keeps running, because the mult/div was issued earlier and is committed.
- id_md_start with ex_branch_taken in the same cycle: ignored, no state change.
- stall_cycles increments on every edge with insert_nop=1 and holds at all-ones (no wrap).
- Async reset mid-MD_WAIT: immediate return to RUN with md_cnt=0; no md_done pulse.

Test Plan:
- Load-use: ex_memread=1, ex_rd=8, id_rs=8, id_uses_rs=1 -> insert_nop=1, pc_en=0, id_ex_bubble=1 for exactly 1 cycle; stall_cycles=1. Repeat with ex_rd=0 -> no stall.
- Branch beats stall: ex_branch_taken=1 with lu_haz active -> PCdst=1, insert_nop=0, id_ex_bubble=1; stall_cycles unchanged.
- Mult then mflo (MD_LATENCY=4): id_md_start=1 one cycle, then id_md_use=1 -> insert_nop high for 3 cycles; md_done pulses once; md_busy falls the cycle after the zero cycle.
- Back-to-back div (MD_LATENCY=4): second id_md_start held in ID -> stalled until md_cnt==0, then reload; md_busy stays 1 continuously for 8 cycles.
- Async reset mid-MD_WAIT at md_cnt=2 -> md_busy=0 and stall_cycles=0 immediately, without waiting for a clk edge; no md_done.
- Saturation (STAT_W=4): hold lu_haz for 20 cycles -> stall_cycles reaches 15 and holds at 15.
